lenet_result_argmax: RTL

Classification back-end for the dual-set LeNet datapath. It snoops the final FC-layer write port (SRAM F) shared by both LeNet sets and tracks a running signed maximum over the class scores of each set. On `fc2_done` it publishes the winning class index of each image through a valid/ready result register. It replaces the host readback of SRAM F for classification.

---
 rtl/lenet_result_argmax.sv | 137 +++++++++++++
 1 files changed

// File: rtl/lenet_result_argmax.sv
// Per-set running signed argmax over SRAM F score writes, published per frame on fc2_done.
// Optional winning-score outputs are enabled with `define ARGMAX_SCORE_OUT_EN.
module lenet_result_argmax #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_CLASS  = 10,
   parameter int IDX_WIDTH  = 4
) (
   input  logic                  clk,
   input  logic                  srst,
   input  logic                  sram_write_enable_f,
   input  logic [3:0]            sram_bytemask_f,
   input  logic [1:0]            sram_waddr_f,
   input  logic [DATA_WIDTH-1:0] sram_wdata_f,
   input  logic [DATA_WIDTH-1:0] sram_wdata_f_1,
   input  logic                  fc2_done,
   output logic                  result_valid,
   input  logic                  result_ready,
   output logic [IDX_WIDTH-1:0]  result_class0,
   output logic [IDX_WIDTH-1:0]  result_class1,
   output logic                  result_incomplete,
   output logic                  overflow
`ifdef ARGMAX_SCORE_OUT_EN
   ,
   output logic [DATA_WIDTH-1:0] result_score0,
   output logic [DATA_WIDTH-1:0] result_score1
`endif
);

   localparam logic [0:0] EMPTY = 1'b0;
   localparam logic [0:0] FULL  = 1'b1;
   localparam logic [4:0] NUM_CLASS_W = 5'(NUM_CLASS);

   logic [0:0]            state;
   logic                  fresh, fresh_nx;
   logic [3:0]            wcnt, wcnt_nx;
   logic [DATA_WIDTH-1:0] max0, max0_nx, max1, max1_nx;
   logic [IDX_WIDTH-1:0]  arg0, arg0_nx, arg1, arg1_nx;
   logic [1:0]            lane;
   logic                  lane_ok;
   logic [3:0]            idx_raw;
   logic [IDX_WIDTH-1:0]  wr_idx;
   logic                  wr_acc;
   logic                  capture;

   // Lowest cleared mask bit selects the lane.
   always_comb begin
      lane    = 2'd0;
      lane_ok = 1'b0;
      for (int i = 3; i >= 0; i--) begin
         if (!sram_bytemask_f[i]) begin
            lane    = 2'(i);
            lane_ok = 1'b1;
         end
      end
   end

   assign idx_raw = {sram_waddr_f, lane};
   assign wr_idx  = IDX_WIDTH'(idx_raw);
   assign wr_acc  = sram_write_enable_f && lane_ok && ({1'b0, idx_raw} < NUM_CLASS_W);

   // Strict greater-than keeps the earlier class on ties.
   always_comb begin
      max0_nx  = max0;
      arg0_nx  = arg0;
      max1_nx  = max1;
      arg1_nx  = arg1;
      fresh_nx = fresh;
      wcnt_nx  = wcnt;
      if (wr_acc) begin
         fresh_nx = 1'b0;
         if (fresh || ($signed(sram_wdata_f) > $signed(max0))) begin
            max0_nx = sram_wdata_f;
            arg0_nx = wr_idx;
         end
         if (fresh || ($signed(sram_wdata_f_1) > $signed(max1))) begin
            max1_nx = sram_wdata_f_1;
            arg1_nx = wr_idx;
         end
         if (wcnt != 4'hF) wcnt_nx = wcnt + 4'd1;
      end
   end

   assign capture      = fc2_done && ((state == EMPTY) || result_ready);
   assign result_valid = (state == FULL);

   always_ff @(posedge clk) begin
      if (srst) begin
         state             <= EMPTY;
         fresh             <= 1'b1;
         wcnt              <= 4'd0;
         max0              <= '0;
         max1              <= '0;
         arg0              <= '0;
         arg1              <= '0;
         result_class0     <= '0;
         result_class1     <= '0;
         result_incomplete <= 1'b0;
         overflow          <= 1'b0;
      end else begin
         max0 <= max0_nx;
         max1 <= max1_nx;
         arg0 <= arg0_nx;
         arg1 <= arg1_nx;
         // Every frame end restarts the running state, whether captured or dropped.
         if (fc2_done) begin
            fresh <= 1'b1;
            wcnt  <= 4'd0;
         end else begin
            fresh <= fresh_nx;
            wcnt  <= wcnt_nx;
         end
         if (capture) begin
            state             <= FULL;
            result_class0     <= fresh_nx ? '0 : arg0_nx;
            result_class1     <= fresh_nx ? '0 : arg1_nx;
            result_incomplete <= ({1'b0, wcnt_nx} < NUM_CLASS_W);
         end else if (fc2_done) begin
            overflow <= 1'b1;
         end else if ((state == FULL) && result_ready) begin
            state <= EMPTY;
         end
      end
   end

`ifdef ARGMAX_SCORE_OUT_EN
   always_ff @(posedge clk) begin
      if (srst) begin
         result_score0 <= '0;
         result_score1 <= '0;
      end else if (capture) begin
         result_score0 <= fresh_nx ? '0 : max0_nx;
         result_score1 <= fresh_nx ? '0 : max1_nx;
      end
   end
`endif

endmodule
